// File: rtl/fifo_rd_arb_pkg.sv
// rtl/fifo_rd_arb_pkg.sv - shared types and defaults for the FIFO read-port arbiter
//
// Purpose : FSM state encoding and default sizing used by fifo_rd_arb and its bench.
// Contents: NREQ_DEF, DSIZE_DEF, state_t {ST_EMPTY, ST_HOLD}.
package fifo_rd_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DSIZE_DEF = 8;

  // ST_HOLD doubles as the output-buffer valid bit.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_rd_arb_rr_arbiter.sv
// rtl/fifo_rd_arb_rr_arbiter.sv - combinational round-robin grant selector
//
// Purpose : picks the first asserted request starting one past last_grant,
//           wrapping modulo NREQ (NREQ need not be a power of two).
// Ports   : req        in  [NREQ-1:0]  request vector
//           last_grant in  [IDW-1:0]   index granted most recently
//           grant      out [IDW-1:0]   selected index (0 when any=0)
//           any        out             at least one request asserted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  grant,
  output logic            any
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest asserted request
  // is the final assignment and therefore wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(last_grant) + k) % NREQ;
      if (req[IDW'(w_idx)]) begin
        grant = IDW'(w_idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// rtl/fifo_rd_arb.sv - shares one FIFO read port among NREQ consumers
//
// Purpose : pops one word per cycle into a single-word output buffer tagged
//           with a round-robin-selected owner; the word stays with that owner
//           until it accepts it.
// Ports   : rclk, rrst_n        read clock, async active-low reset
//           rempty, fifo_rdata  FIFO empty flag and head-of-FIFO data
//           rinc                FIFO pop strobe
//           req, ready          per-consumer request / accept
//           lock                per-consumer burst lock (FIFO_RD_ARB_LOCK_EN only)
//           valid, rdata, owner held word: one-hot valid, data, owner index
// Macro   : FIFO_RD_ARB_LOCK_EN adds the lock input and burst-lock grant hold.
module fifo_rd_arb
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DSIZE = DSIZE_DEF,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  ready,
`ifdef FIFO_RD_ARB_LOCK_EN
  input  logic [NREQ-1:0]  lock,
`endif
  output logic [NREQ-1:0]  valid,
  output logic [DSIZE-1:0] rdata,
  output logic [IDW-1:0]   owner
);

  state_t           r_state;
  logic [DSIZE-1:0] r_buf_data;
  logic [IDW-1:0]   r_buf_owner;
  logic [IDW-1:0]   r_last_grant;

  logic             w_buf_valid;
  logic             w_xfer;
  logic             w_any;
  logic [IDW-1:0]   w_arb_grant;
  logic [IDW-1:0]   w_grant;

  assign w_buf_valid = (r_state == ST_HOLD);

  // Only the owner's ready matters; everyone else's is ignored.
  assign w_xfer = w_buf_valid & ready[r_buf_owner];

  // Gated by rrst_n so the strobe is low for the whole reset, even though
  // the buffer is already empty and the FIFO may present data.
  assign rinc = rrst_n & ~rempty & w_any & (~w_buf_valid | w_xfer);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .any        (w_any)
  );

`ifdef FIFO_RD_ARB_LOCK_EN
  // Burst lock: the previous winner keeps the port while it holds both
  // lock and req.
  assign w_grant = (lock[r_last_grant] & req[r_last_grant]) ? r_last_grant : w_arb_grant;
`else
  assign w_grant = w_arb_grant;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state      <= ST_EMPTY;
      r_buf_data   <= '0;
      r_buf_owner  <= '0;
      r_last_grant <= IDW'(NREQ - 1);
    end else begin
      case (r_state)
        ST_EMPTY: if (rinc) r_state <= ST_HOLD;
        ST_HOLD:  if (w_xfer && !rinc) r_state <= ST_EMPTY;
      endcase
      // A pop in HOLD only happens alongside xfer, so the held word is
      // never overwritten before its owner takes it.
      if (rinc) begin
        r_buf_data   <= fifo_rdata;
        r_buf_owner  <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  always_comb begin
    valid              = '0;
    valid[r_buf_owner] = w_buf_valid;
  end

  assign rdata = r_buf_data;
  assign owner = r_buf_owner;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb/tb_fifo_rd_arb.sv - self-checking bench for fifo_rd_arb
module tb_fifo_rd_arb;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] fifo_rdata;
  logic       rinc;
  logic [3:0] req;
  logic [3:0] ready;
  logic [3:0] lock;
  logic [3:0] valid;
  logic [7:0] rdata;
  logic [1:0] owner;

  fifo_rd_arb dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .fifo_rdata (fifo_rdata),
    .rinc       (rinc),
    .req        (req),
    .ready      (ready),
`ifdef FIFO_RD_ARB_LOCK_EN
    .lock       (lock),
`endif
    .valid      (valid),
    .rdata      (rdata),
    .owner      (owner)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Reference model: FIFO contents as a queue, the held word as a record,
  // and the last granted index as an integer.
  logic [7:0] fifo_q[$];
  bit         m_bv;
  logic [7:0] m_bd;
  int         m_bo;
  int         m_last;

  logic [3:0] req_v;
  logic [3:0] ready_v;
  logic [3:0] lock_v;

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    rempty     = (fifo_q.size() == 0);
    fifo_rdata = rempty ? 8'h00 : fifo_q[0];
    req        = req_v;
    ready      = ready_v;
    lock       = lock_v;
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      if (g < 0 && req_v[(m_last + k) % 4]) g = (m_last + k) % 4;
    end
`ifdef FIFO_RD_ARB_LOCK_EN
    if (lock_v[m_last] && req_v[m_last]) g = m_last;
`endif
    return g;
  endfunction

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic step();
    bit         xfer;
    bit         e_rinc;
    int         g;
    logic [3:0] e_valid;
    drive();
    #1;
    xfer    = m_bv && ready_v[m_bo];
    e_rinc  = (fifo_q.size() != 0) && (req_v != 4'b0) && (!m_bv || xfer);
    g       = model_grant();
    e_valid = m_bv ? 4'(1 << m_bo) : 4'b0000;
    chk("rinc", 32'(rinc), 32'(e_rinc));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("rdata", 32'(rdata), 32'(m_bd));
    chk("owner", 32'(owner), 32'(m_bo));
    @(posedge rclk);
    if (e_rinc) begin
      m_bd   = fifo_q.pop_front();
      m_bv   = 1'b1;
      m_bo   = g;
      m_last = g;
    end else if (xfer) begin
      m_bv = 1'b0;
    end
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    drive();
    #1;
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    m_bv   = 1'b0;
    m_bd   = 8'h00;
    m_bo   = 0;
    m_last = 3;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rrst_n  = 1'b0;
    req_v   = 4'b0;
    ready_v = 4'b0;
    lock_v  = 4'b0;
    m_bv    = 1'b0;
    m_bd    = 8'h00;
    m_bo    = 0;
    m_last  = 3;
    drive();
    @(negedge rclk);

    // Reset with a non-empty FIFO and all requests up: nothing may pop.
    fifo_q.push_back(8'h11);
    req_v = 4'b1111;
    do_reset();
    fifo_q.delete();

    // Single consumer, first pop and 1-cycle latency.
    fifo_q.push_back(8'hA5);
    req_v   = 4'b0001;
    ready_v = 4'b1111;
    step();
    chk("r034_valid", 32'(valid), 32'h1);
    chk("r034_rdata", 32'(rdata), 32'hA5);
    chk("r034_owner", 32'(owner), 32'h0);
    step();

    // Four requesters, eight words back to back.
    req_v = 4'b0000;
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h20 + 8'(i));
    req_v   = 4'b1111;
    ready_v = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("r035_owner", 32'(owner), 32'(i % 4));
      chk("r035_data", 32'(rdata), 32'(8'h20 + 8'(i)));
    end
    step();

    // Owner stalls for three cycles, then accepts with a pop in the same cycle.
    fifo_q.push_back(8'h36);
    fifo_q.push_back(8'h37);
    req_v   = 4'b0100;
    ready_v = 4'b0000;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r036_hold", 32'(valid), 32'h4);
      chk("r036_data", 32'(rdata), 32'h36);
    end
    ready_v = 4'b0100;
    step();
    chk("r036_next", 32'(rdata), 32'h37);
    step();

    // Owner drops req while its word is held: word is not retracted.
    fifo_q.push_back(8'h41);
    fifo_q.push_back(8'h42);
    req_v   = 4'b0010;
    ready_v = 4'b0000;
    step();
    req_v   = 4'b0000;
    ready_v = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r037_hold", 32'(valid), 32'h2);
      chk("r037_data", 32'(rdata), 32'h41);
    end
    ready_v = 4'b1111;
    step();
    step();
    fifo_q.delete();

    // Empty FIFO blocks pops; first pop after it fills goes to index 0.
    do_reset();
    req_v   = 4'b1111;
    ready_v = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    fifo_q.push_back(8'h5C);
    step();
    chk("r038_owner", 32'(owner), 32'h0);
    chk("r038_data", 32'(rdata), 32'h5C);
    step();

    // Reset while holding a word: word is discarded, grant restarts at 0.
    fifo_q.push_back(8'h61);
    fifo_q.push_back(8'h62);
    req_v   = 4'b0100;
    ready_v = 4'b0000;
    step();
    step();
    req_v = 4'b1111;
    do_reset();
    ready_v = 4'b1111;
    step();
    chk("r039_owner", 32'(owner), 32'h0);
    chk("r039_data", 32'(rdata), 32'h62);
    step();

`ifdef FIFO_RD_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'h70 + 8'(i));
    req_v   = 4'b0011;
    ready_v = 4'b1111;
    lock_v  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_owner", 32'(owner), 32'h0);
    end
    lock_v = 4'b0000;
    step();
    chk("unlock_owner", 32'(owner), 32'h1);
    step();
    step();
    lock_v = 4'b0000;
`endif

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) != 0) fifo_q.push_back(8'($urandom));
      req_v   = 4'($urandom);
      ready_v = 4'($urandom);
`ifdef FIFO_RD_ARB_LOCK_EN
      lock_v  = 4'($urandom);
`endif
      if ($urandom_range(0, 63) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arb.md
FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 Parameter NREQ, default 4: number of consumers sharing one FIFO read port.
REQ-002 Parameter DSIZE, default 8: FIFO data word width.
REQ-003 Parameter IDW, default $clog2(NREQ): owner-id width.
REQ-004 rclk  input  1  read-domain clock, all logic on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 rempty  input  1  FIFO empty flag, read domain.
REQ-007 fifo_rdata  input  DSIZE  FIFO memory data at current raddr, valid whenever rempty is low.
REQ-008 rinc  output  1  FIFO pop strobe, one word per cycle high.
REQ-009 req  input  NREQ  per-consumer data request, level.
REQ-010 ready  input  NREQ  per-consumer accept.
REQ-011 valid  output  NREQ  per-consumer data valid, at most one bit high.
REQ-012 rdata  output  DSIZE  shared data bus to consumers.
REQ-013 owner  output  IDW  index of consumer owning the held word.

Function
REQ-014 Block SHALL hold a one-word output buffer (buf_valid, buf_data, buf_owner) and SHALL run a 2-state FSM: EMPTY (buf_valid=0) and HOLD (buf_valid=1).
REQ-015 xfer SHALL be defined as buf_valid & ready[buf_owner].
REQ-016 rinc SHALL equal ~rempty & |req & (~buf_valid | xfer), combinationally.
REQ-017 On a cycle with rinc=1, buffer SHALL load fifo_rdata and the granted index, buf_valid=1 next cycle: pop-to-valid latency exactly 1 cycle.
REQ-018 Back-to-back: xfer and rinc in same cycle SHALL keep HOLD with new word, sustaining 1 word/cycle.
REQ-019 xfer with rinc=0 SHALL go HOLD->EMPTY; rinc in EMPTY SHALL go EMPTY->HOLD; no other transitions.
REQ-020 valid SHALL be one-hot at buf_owner when buf_valid, else all zero; rdata=buf_data; owner=buf_owner.
REQ-021 Grant SHALL be round-robin: search starts at (last_grant+1) mod NREQ, first asserted req wins; last_grant updates only on rinc.
REQ-022 A committed word SHALL stay with its owner until ready; dropping req[owner] SHALL NOT retract or reassign it.
REQ-023 rempty high SHALL force rinc=0 regardless of req; buffer contents unaffected.
REQ-024 req all zero SHALL force rinc=0; grant pointer unchanged.
REQ-025 ready bits of non-owners SHALL be ignored.
REQ-026 Grant index arithmetic SHALL wrap modulo NREQ for non-power-of-two NREQ.

Reset
REQ-027 rrst_n low SHALL asynchronously clear buf_valid, buf_data, buf_owner to 0, last_grant to NREQ-1 (first grant favours index 0), FSM to EMPTY.
REQ-028 Outputs during reset SHALL be rinc=0, valid=0, rdata=0, owner=0.
REQ-029 Reset mid-HOLD SHALL discard the held word; it is not re-presented.

Configuration
REQ-030 Macro FIFO_RD_ARB_LOCK_EN defined: input lock [NREQ] SHALL exist; while lock[last_grant] & req[last_grant], next grant SHALL stay with last_grant (burst lock).
REQ-031 Macro undefined: lock port SHALL be absent and arbitration pure per-word round-robin.

Structure
REQ-032 Package fifo_rd_arb_pkg SHALL hold the FSM state enum (ST_EMPTY, ST_HOLD) and default NREQ/DSIZE constants.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req, last_grant; output grant index, any).

Verification
REQ-034 Reset, then req=4'b0001, rempty=0, ready=1, fifo_rdata=8'hA5 -> rinc=1 cycle 0, valid=4'b0001, rdata=8'hA5, owner=0 cycle 1.
REQ-035 req=4'b1111, ready=1, FIFO holds 8 words -> owners 0,1,2,3,0,1,2,3 on consecutive cycles, rinc high 8 cycles.
REQ-036 req=4'b0100, ready[2]=0 for 3 cycles -> valid=4'b0100 held 3 cycles, rinc=0, word delivered on cycle ready[2] rises.
REQ-037 Word held for owner 1, req[1] drops, ready[1]=0 -> valid stays 4'b0010 with same data; no pop.
REQ-038 rempty=1 with req=4'b1111 -> rinc=0, valid=0 indefinitely; rempty falls -> pop to owner 0 next cycle.
REQ-039 rrst_n low during HOLD -> valid=0, rinc=0 immediately; after release first grant goes to index 0; with FIFO_RD_ARB_LOCK_EN and lock[0]=1, req=4'b0011 -> owner 0 for all beats until lock[0] drops.
